// File: rtl/digest_can_framer.sv
// rtl/digest_can_framer.sv - packs a RAM-resident digest into classic-CAN data frames
//
// Purpose: after the hash engine finishes, reads DIGEST_BYTES bytes from RAM
// starting at digest_addr and emits them as DIGEST_BYTES/FRAME_BYTES CAN data
// frames over a valid/ready handshake. The block drives the RAM read port only
// while busy; mem_addr is held at 0 whenever mem_oe is low.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous, active-low reset
//   start        in   begin framing (sampled only while idle)
//   digest_addr  in   RAM address of digest byte 0
//   mem_addr     out  RAM read address
//   mem_oe       out  RAM read strobe
//   mem_data     in   RAM read data, valid RD_LAT cycles after its address
//   frame_valid  out  frame_* fields valid
//   frame_ready  in   CAN TX accepts the frame
//   frame_id     out  11-bit standard identifier (BASE_ID + frame index)
//   frame_dlc    out  data length code
//   frame_data   out  payload, byte 0 in the MSBs
//   busy         out  high whenever not idle
//   done         out  one-cycle pulse after the last frame is accepted

module digest_can_framer #(
  parameter int          ADDR_W       = 10,
  parameter int          DATA_W       = 8,
  parameter int          DIGEST_BYTES = 32,
  parameter int          FRAME_BYTES  = 8,
  parameter logic [10:0] BASE_ID      = 11'h100,
  parameter int          RD_LAT       = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        digest_addr,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_oe,
  input  logic [DATA_W-1:0]        mem_data,
  output logic                     frame_valid,
  input  logic                     frame_ready,
  output logic [10:0]              frame_id,
  output logic [3:0]               frame_dlc,
  output logic [8*FRAME_BYTES-1:0] frame_data,
  output logic                     busy,
  output logic                     done
);

  localparam int NFRAMES = DIGEST_BYTES / FRAME_BYTES;
  localparam int FCNT_W  = (NFRAMES > 1) ? $clog2(NFRAMES) : 1;
  localparam int BCNT_W  = $clog2(FRAME_BYTES + 1);
  localparam int PAY_W   = 8 * FRAME_BYTES;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [FCNT_W-1:0]   frame_q, frame_d;
  logic [BCNT_W-1:0]   iss_q, iss_d;      // addresses issued for the current frame
  logic [BCNT_W-1:0]   cap_q, cap_d;      // bytes captured for the current frame
  logic [RD_LAT-1:0]   rd_pipe_q, rd_pipe_d;
  logic [PAY_W-1:0]    payload_q, payload_d;

  logic                issue;
  logic                capture;
  logic                send;
  logic [ADDR_W-1:0]   frame_off;

  // A read is in flight for RD_LAT cycles; the MSB of the pipe marks the
  // cycle in which mem_data belongs to the oldest outstanding address.
  always_comb begin
    issue     = (state_q == S_LOAD) && (iss_q < BCNT_W'(FRAME_BYTES));
    capture   = (state_q == S_LOAD) && rd_pipe_q[RD_LAT-1];
    send      = (state_q == S_SEND);
    frame_off = ADDR_W'(frame_q) * ADDR_W'(FRAME_BYTES);
  end

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    frame_d   = frame_q;
    iss_d     = iss_q;
    cap_d     = cap_q;
    payload_d = payload_q;
    rd_pipe_d = (rd_pipe_q << 1) | RD_LAT'(issue);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d    = digest_addr;
          frame_d   = '0;
          iss_d     = '0;
          cap_d     = '0;
          payload_d = '0;
          rd_pipe_d = '0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (issue) begin
          iss_d = iss_q + 1'b1;
        end
        if (capture) begin
          for (int b = 0; b < FRAME_BYTES; b++) begin
            if (cap_q == BCNT_W'(b)) begin
              payload_d[8*(FRAME_BYTES-b)-1 -: 8] = mem_data;
            end
          end
          cap_d = cap_q + 1'b1;
          if (cap_q == BCNT_W'(FRAME_BYTES - 1)) begin
            state_d = S_SEND;
          end
        end
      end
      S_SEND: begin
        if (frame_ready) begin
          if (frame_q == FCNT_W'(NFRAMES - 1)) begin
            state_d = S_DONE;
          end else begin
            frame_d = frame_q + 1'b1;
            iss_d   = '0;
            cap_d   = '0;
            state_d = S_LOAD;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      frame_q   <= '0;
      iss_q     <= '0;
      cap_q     <= '0;
      rd_pipe_q <= '0;
      payload_q <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      frame_q   <= frame_d;
      iss_q     <= iss_d;
      cap_q     <= cap_d;
      rd_pipe_q <= rd_pipe_d;
      payload_q <= payload_d;
    end
  end

  // Frame fields are forced to 0 outside SEND so a partially loaded payload
  // never appears on the bus.
  always_comb begin
    mem_oe      = issue;
    mem_addr    = issue ? (base_q + frame_off + ADDR_W'(iss_q)) : '0;
    frame_valid = send;
    frame_id    = send ? (BASE_ID + 11'(frame_q)) : 11'h000;
    frame_dlc   = send ? 4'(FRAME_BYTES) : 4'h0;
    frame_data  = send ? payload_q : '0;
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_digest_can_framer.sv
// tb/tb_digest_can_framer.sv - self-checking bench for digest_can_framer

module tb_digest_can_framer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  digest_addr = 10'h000;
  logic [9:0]  mem_addr;
  logic        mem_oe;
  logic [7:0]  mem_data;
  logic        frame_valid;
  logic        frame_ready = 1'b0;
  logic [10:0] frame_id;
  logic [3:0]  frame_dlc;
  logic [63:0] frame_data;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  digest_can_framer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .digest_addr (digest_addr),
    .mem_addr    (mem_addr),
    .mem_oe      (mem_oe),
    .mem_data    (mem_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_id    (frame_id),
    .frame_dlc   (frame_dlc),
    .frame_data  (frame_data),
    .busy        (busy),
    .done        (done)
  );

  // RAM with one cycle of read latency
  logic [7:0] ram [0:1023];
  always @(posedge clk) if (mem_oe) mem_data <= ram[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_data(input logic [9:0] b, input int f);
    logic [63:0] d;
    d = '0;
    for (int j = 0; j < 8; j++) d = {d[55:0], ram[10'(b + 8 * f + j)]};
    return d;
  endfunction

  // Behavioural model: a run is a base address plus a frame index; each frame
  // starts at a trigger edge (start accept or previous handshake), reads bytes
  // in the 8 cycles after it, and is offered from 9 cycles after it onwards.
  bit          m_active = 0, m_valid = 0, m_done = 0, m_after_rst = 0;
  int          m_frame = 0, m_trig = 0;
  logic [9:0]  m_base = '0;

  int          done_cnt = 0;
  int          first_valid_cyc = -1;
  logic [10:0] acc_id[$];
  logic [63:0] acc_data[$];

  always @(negedge clk) begin : monitor
    int         k;
    logic       exp_oe;
    logic [9:0] exp_addr;
    if (cyc > 0) begin
      k        = cyc - m_trig;
      exp_oe   = m_active && !m_valid && !m_done && (k >= 0) && (k < 8);
      exp_addr = exp_oe ? 10'(m_base + 8 * m_frame + k) : 10'h000;
      chk("busy",        busy,        m_active);
      chk("done",        done,        m_done);
      chk("frame_valid", frame_valid, m_valid);
      chk("mem_oe",      mem_oe,      exp_oe);
      chk("mem_addr",    mem_addr,    exp_addr);
      if (m_valid) begin
        chk("frame_id",   frame_id,   11'(11'h100 + m_frame));
        chk("frame_dlc",  frame_dlc,  4'd8);
        chk("frame_data", frame_data, exp_data(m_base, m_frame));
      end
      if (m_after_rst) begin
        chk("rst_frame_id",   frame_id,   0);
        chk("rst_frame_dlc",  frame_dlc,  0);
        chk("rst_frame_data", frame_data, 0);
      end
      if (done) done_cnt++;
      if (frame_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (frame_valid && frame_ready) begin
        acc_id.push_back(frame_id);
        acc_data.push_back(frame_data);
      end
    end
    m_after_rst = 0;
    if (!rst) begin
      m_active = 0; m_valid = 0; m_done = 0; m_after_rst = 1;
    end else if (m_done) begin
      m_done = 0; m_active = 0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1; m_frame = 0; m_trig = cyc + 1; m_base = digest_addr;
      end
    end else if (m_valid) begin
      if (frame_ready) begin
        m_valid = 0;
        if (m_frame == 3) m_done = 1;
        else begin
          m_frame++;
          m_trig = cyc + 1;
        end
      end
    end else if (cyc + 1 - m_trig == 9) begin
      m_valid = 1;
    end
  end

  // Ready driver: 0 = always ready, 1 = hold off 5 valid cycles, 2 = random
  int ready_mode = 0;
  initial begin : ready_drv
    int wcnt;
    wcnt = 0;
    forever begin
      @(posedge clk); #1;
      if (!frame_valid) begin
        wcnt = 0;
        frame_ready = (ready_mode == 0) ? 1'b1 :
                      (ready_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      end else begin
        case (ready_mode)
          0:       frame_ready = 1'b1;
          1:       frame_ready = (wcnt >= 5);
          default: frame_ready = 1'($urandom_range(0, 1));
        endcase
        wcnt++;
      end
    end
  end

  int start_cyc = 0;

  task automatic pulse_start(input logic [9:0] base);
    @(posedge clk); #1;
    digest_addr = base;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_timeout", n < 2000, 1);
  endtask

  task automatic clear_logs();
    acc_id.delete();
    acc_data.delete();
    done_cnt = 0;
    first_valid_cyc = -1;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 1024; i++) ram[i] = 8'($urandom);
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int n;
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("reset_busy", busy, 0);
    chk("reset_valid", frame_valid, 0);
    chk("reset_oe", mem_oe, 0);

    // 1: bytes 00..1F at 64, always ready
    for (int i = 0; i < 32; i++) ram[64 + i] = 8'(i);
    ready_mode = 0;
    clear_logs();
    pulse_start(10'd64);
    wait_done();
    settle();
    chk("t1_nframes", acc_id.size(), 4);
    chk("t1_id0", acc_id[0], 11'h100);
    chk("t1_id3", acc_id[3], 11'h103);
    chk("t1_data0", acc_data[0], 64'h0001020304050607);
    chk("t1_data3", acc_data[3], 64'h18191A1B1C1D1E1F);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_first_valid_latency", first_valid_cyc - start_cyc, 9);

    // 2: back-pressure for 5 cycles per frame
    fill_random();
    ready_mode = 1;
    clear_logs();
    pulse_start(10'($urandom));
    wait_done();
    settle();
    chk("t2_nframes", acc_id.size(), 4);
    chk("t2_done_cnt", done_cnt, 1);

    // 3: address wrap 3FF -> 000 during frame 1
    for (int i = 0; i < 1024; i++) ram[i] = 8'(i);
    ready_mode = 2;
    clear_logs();
    pulse_start(10'h3F8);
    wait_done();
    settle();
    chk("t3_data0", acc_data[0], 64'hF8F9FAFBFCFDFEFF);
    chk("t3_data1", acc_data[1], 64'h0001020304050607);
    chk("t3_nframes", acc_id.size(), 4);

    // 4: reset during LOAD of frame 2, then a fresh run
    fill_random();
    ready_mode = 0;
    clear_logs();
    pulse_start(10'h040);
    repeat (22) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("t4_busy_after_rst", busy, 0);
    chk("t4_nframes_before_rst", acc_id.size(), 2);
    clear_logs();
    pulse_start(10'h123);
    wait_done();
    settle();
    chk("t4_id0_restart", acc_id[0], 11'h100);
    chk("t4_nframes", acc_id.size(), 4);

    // 5: start re-pulsed during LOAD and SEND
    fill_random();
    ready_mode = 2;
    clear_logs();
    pulse_start(10'($urandom));
    n = 0;
    while (!done && n < 2000) begin
      @(posedge clk); #1;
      start = done ? 1'b0 : 1'($urandom_range(0, 1));
      n++;
    end
    start = 1'b0;
    chk("t5_timeout", n < 2000, 1);
    settle();
    chk("t5_nframes", acc_id.size(), 4);
    chk("t5_done_cnt", done_cnt, 1);

    // 6: back-to-back runs, second start in the cycle after done
    ready_mode = 0;
    clear_logs();
    pulse_start(10'h200);
    wait_done();
    pulse_start(10'h2F0);
    wait_done();
    settle();
    chk("t6_nframes", acc_id.size(), 8);
    chk("t6_id4", acc_id[4], 11'h100);
    chk("t6_id7", acc_id[7], 11'h103);
    chk("t6_done_cnt", done_cnt, 2);

    // randomized runs
    for (int r = 0; r < 6; r++) begin
      fill_random();
      ready_mode = $urandom_range(0, 2);
      clear_logs();
      pulse_start(10'($urandom));
      wait_done();
      settle();
      chk("rand_nframes", acc_id.size(), 4);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
